// File: rtl/spi_flash_cmd_sequencer.sv
// Serial-flash operation sequencer: walks program / sector-erase / status-read byte
// sequences through a start/done byte engine, polling the busy bit where needed.
module spi_flash_cmd_sequencer #(
  parameter logic [11:0] ADDR_HI   = 12'h000,
  parameter logic [15:0] MAX_POLLS = 16'd16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [1:0]  req_op,
  input  logic [11:0] req_addr,
  input  logic [7:0]  req_data,
  output logic        req_ready,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [7:0]  status,
  output logic        eng_start,
  output logic [7:0]  eng_tx,
  output logic        eng_cs_hold,
  input  logic        eng_done,
  input  logic [7:0]  eng_rx,
  output logic [3:0]  state_dbg
);

  typedef enum logic [3:0] {
    S_IDLE, S_WREN, S_CMD, S_A2, S_A1, S_A0, S_DATA, S_POLL_CMD,
    S_POLL_RD, S_CHECK, S_RS_CMD, S_RS_RD, S_FAIL, S_DONE
  } state_t;

  // Handshake: eng_start is a one-cycle pulse on the first cycle of each byte
  // state; eng_tx/eng_cs_hold are decoded from the state and stay stable until
  // eng_done, which is honoured only after the start cycle (started=1).

  state_t      state, state_nx, state_d;
  logic        started;
  logic [1:0]  op_q;
  logic [23:0] addr_q;
  logic [7:0]  data_q;
  logic [15:0] poll_cnt;
  logic        byte_state;
  logic        adv;
  logic        is_erase;

  assign is_erase  = (op_q == 2'b01);
  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign state_dbg = state;

  always_comb begin
    byte_state = 1'b0;
    case (state)
      S_WREN, S_CMD, S_A2, S_A1, S_A0, S_DATA,
      S_POLL_CMD, S_POLL_RD, S_RS_CMD, S_RS_RD: byte_state = 1'b1;
      default: byte_state = 1'b0;
    endcase
  end

  assign eng_start = byte_state && !started;
  assign adv       = byte_state ? (started && eng_done) : 1'b1;
  assign state_d   = adv ? state_nx : state;

  always_comb begin
    state_nx    = state;
    eng_tx      = 8'h00;
    eng_cs_hold = 1'b0;
    case (state)
      S_IDLE: begin
        if (req_valid) begin
          case (req_op)
            2'b00, 2'b01: state_nx = S_WREN;
            2'b10:        state_nx = S_RS_CMD;
            default:      state_nx = S_FAIL;
          endcase
        end
      end
      S_WREN: begin
        eng_tx   = 8'h06;
        state_nx = S_CMD;
      end
      S_CMD: begin
        eng_tx      = is_erase ? 8'h20 : 8'h02;
        eng_cs_hold = 1'b1;
        state_nx    = S_A2;
      end
      S_A2: begin
        eng_tx      = addr_q[23:16];
        eng_cs_hold = 1'b1;
        state_nx    = S_A1;
      end
      S_A1: begin
        eng_tx      = addr_q[15:8];
        eng_cs_hold = 1'b1;
        state_nx    = S_A0;
      end
      S_A0: begin
        // Erase frame ends on the last address byte; program continues with data.
        eng_tx      = addr_q[7:0];
        eng_cs_hold = !is_erase;
        state_nx    = is_erase ? S_POLL_CMD : S_DATA;
      end
      S_DATA: begin
        eng_tx   = data_q;
        state_nx = S_POLL_CMD;
      end
      S_POLL_CMD: begin
        eng_tx      = 8'h05;
        eng_cs_hold = 1'b1;
        state_nx    = S_POLL_RD;
      end
      S_POLL_RD: begin
        eng_tx   = 8'h00;
        state_nx = S_CHECK;
      end
      S_CHECK: begin
        if (!status[0])                 state_nx = S_DONE;
        else if (poll_cnt == MAX_POLLS) state_nx = S_FAIL;
        else                            state_nx = S_POLL_CMD;
      end
      S_RS_CMD: begin
        eng_tx      = 8'h05;
        eng_cs_hold = 1'b1;
        state_nx    = S_RS_RD;
      end
      S_RS_RD: begin
        eng_tx   = 8'h00;
        state_nx = S_DONE;
      end
      S_FAIL:  state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_IDLE;
      started  <= 1'b0;
      op_q     <= 2'b00;
      addr_q   <= 24'h000000;
      data_q   <= 8'h00;
      status   <= 8'h00;
      error    <= 1'b0;
      poll_cnt <= 16'd0;
    end else begin
      state   <= state_d;
      started <= byte_state && !adv;
      if (state == S_IDLE && req_valid) begin
        op_q     <= req_op;
        addr_q   <= {ADDR_HI, req_addr};
        data_q   <= req_data;
        error    <= 1'b0;
        poll_cnt <= 16'd0;
      end
      if (adv && state == S_POLL_RD) begin
        status   <= eng_rx;
        poll_cnt <= poll_cnt + 16'd1;
      end
      if (adv && state == S_RS_RD) status <= eng_rx;
      if (state == S_FAIL) error <= 1'b1;
      if (state == S_DONE) poll_cnt <= 16'd0;
    end
  end

endmodule

// File: tb/tb_spi_flash_cmd_sequencer.sv
// Directed bench for spi_flash_cmd_sequencer with a behavioural byte-engine
// responder that logs every launched byte as {cs_hold, tx}.
module tb_spi_flash_cmd_sequencer;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [11:0] req_addr;
  logic [7:0]  req_data;
  logic        req_ready;
  logic        busy;
  logic        done;
  logic        error;
  logic [7:0]  status;
  logic        eng_start;
  logic [7:0]  eng_tx;
  logic        eng_cs_hold;
  logic        eng_done;
  logic [7:0]  eng_rx;
  logic [3:0]  state_dbg;

  int errors = 0;
  int checks = 0;

  logic [8:0] exp_q[$];
  logic [8:0] log_q[$];
  logic [7:0] rx_q[$];
  logic [7:0] rx_default;
  logic [7:0] pending_rx;
  logic [7:0] prev_tx;
  int         cd;
  int         done_total;

  spi_flash_cmd_sequencer #(.ADDR_HI(12'h001), .MAX_POLLS(16'd4)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_op(req_op),
    .req_addr(req_addr), .req_data(req_data), .req_ready(req_ready),
    .busy(busy), .done(done), .error(error), .status(status),
    .eng_start(eng_start), .eng_tx(eng_tx), .eng_cs_hold(eng_cs_hold),
    .eng_done(eng_done), .eng_rx(eng_rx), .state_dbg(state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte engine: eng_done arrives on the third falling edge after eng_start.
  initial begin
    eng_done = 1'b0; eng_rx = 8'h00; cd = 0; done_total = 0;
    prev_tx = 8'h00; pending_rx = 8'h00; rx_default = 8'h00;
  end
  always @(negedge clk) begin
    if (done) done_total++;
    if (eng_done) eng_done = 1'b0;
    if (cd > 0) begin
      cd--;
      if (cd == 0) begin
        eng_done = 1'b1;
        eng_rx   = pending_rx;
      end
    end
    if (eng_start) begin
      log_q.push_back({eng_cs_hold, eng_tx});
      if (eng_tx == 8'h00 && prev_tx == 8'h05)
        pending_rx = (rx_q.size() > 0) ? rx_q.pop_front() : rx_default;
      else
        pending_rx = 8'hEE;
      prev_tx = eng_tx;
      cd = 2;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic exp_add(input logic hold, input logic [7:0] tx);
    exp_q.push_back({hold, tx});
  endtask

  task automatic start_req(input logic [1:0] op, input logic [11:0] addr, input logic [7:0] data);
    log_q.delete();
    req_valid = 1'b1; req_op = op; req_addr = addr; req_data = data;
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int lat);
    lat = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge clk);
      if (done) begin
        lat = i;
        break;
      end
    end
    if (lat == 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic compare_log(input string tag);
    int n;
    check({tag, "_len"}, log_q.size(), exp_q.size());
    n = (log_q.size() < exp_q.size()) ? log_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) check($sformatf("%s_byte%0d", tag, i), log_q[i], exp_q[i]);
    exp_q.delete();
  endtask

  task automatic wait_tx_start(input logic [7:0] tx, input int budget);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (eng_start && eng_tx == tx) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) check("start_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int lat;
    int d0;
    reset = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_addr = 12'h000; req_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_start", eng_start, 0);
    check("rst_hold", eng_cs_hold, 0);
    check("rst_tx", eng_tx, 8'h00);
    check("rst_status", status, 8'h00);
    reset = 1'b1;
    @(negedge clk);

    // Program 0x001123 <- A5; first poll busy, second ready; busy-time request ignored
    rx_q = '{8'h01, 8'h00};
    d0 = done_total;
    start_req(2'b00, 12'h123, 8'hA5);
    wait_tx_start(8'h11, 50);
    req_valid = 1'b1; req_op = 2'b01; req_addr = 12'hFFF; req_data = 8'h3C;
    repeat (3) @(negedge clk);
    req_valid = 1'b0;
    wait_done(200, lat);
    check("prog_error", error, 0);
    check("prog_status", status, 8'h00);
    repeat (3) @(negedge clk);
    check("prog_done_pulses", done_total - d0, 1);
    check("prog_idle", req_ready, 1);
    exp_add(0, 8'h06); exp_add(1, 8'h02); exp_add(1, 8'h00); exp_add(1, 8'h11);
    exp_add(1, 8'h23); exp_add(0, 8'hA5); exp_add(1, 8'h05); exp_add(0, 8'h00);
    exp_add(1, 8'h05); exp_add(0, 8'h00);
    compare_log("prog");

    // Erase 0x001FFF; ready on third poll
    rx_q = '{8'h01, 8'h01, 8'h00};
    start_req(2'b01, 12'hFFF, 8'h00);
    wait_done(200, lat);
    check("erase_error", error, 0);
    check("erase_status", status, 8'h00);
    exp_add(0, 8'h06); exp_add(1, 8'h20); exp_add(1, 8'h00); exp_add(1, 8'h1F);
    exp_add(0, 8'hFF);
    for (int i = 0; i < 3; i++) begin exp_add(1, 8'h05); exp_add(0, 8'h00); end
    repeat (2) @(negedge clk);
    compare_log("erase");

    // Timeout: status stays 03, MAX_POLLS=4
    rx_q.delete();
    rx_default = 8'h03;
    start_req(2'b01, 12'h000, 8'h00);
    wait_done(300, lat);
    check("tmo_error", error, 1);
    check("tmo_status", status, 8'h03);
    exp_add(0, 8'h06); exp_add(1, 8'h20); exp_add(1, 8'h00); exp_add(1, 8'h10);
    exp_add(0, 8'h00);
    for (int i = 0; i < 4; i++) begin exp_add(1, 8'h05); exp_add(0, 8'h00); end
    repeat (2) @(negedge clk);
    compare_log("tmo");
    rx_default = 8'h00;

    // Status read: error from timeout clears on acceptance
    rx_q = '{8'h5C};
    start_req(2'b10, 12'h000, 8'h00);
    check("rs_error_cleared", error, 0);
    wait_done(50, lat);
    check("rs_latency_ok", (lat > 0 && lat <= 10), 1);
    check("rs_status", status, 8'h5C);
    check("rs_error", error, 0);
    exp_add(1, 8'h05); exp_add(0, 8'h00);
    repeat (2) @(negedge clk);
    compare_log("rs");

    // Illegal op: no bytes, done+error quickly
    start_req(2'b11, 12'h000, 8'h00);
    wait_done(10, lat);
    check("ill_latency_ok", (lat > 0 && lat <= 3), 1);
    check("ill_error", error, 1);
    check("ill_status", status, 8'h5C);
    repeat (2) @(negedge clk);
    check("ill_no_bytes", log_q.size(), 0);

    // Reset while the data byte is in flight
    rx_q.delete();
    start_req(2'b00, 12'h123, 8'hA5);
    wait_tx_start(8'hA5, 80);
    reset = 1'b0;
    @(negedge clk);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", req_ready, 1);
    check("mid_rst_hold", eng_cs_hold, 0);
    check("mid_rst_status", status, 8'h00);
    check("mid_rst_error", error, 0);
    reset = 1'b1;
    repeat (6) @(negedge clk);
    rx_q = '{8'h00};
    start_req(2'b00, 12'h123, 8'hA5);
    wait_done(200, lat);
    check("post_rst_error", error, 0);
    check("post_rst_status", status, 8'h00);
    exp_add(0, 8'h06); exp_add(1, 8'h02); exp_add(1, 8'h00); exp_add(1, 8'h11);
    exp_add(1, 8'h23); exp_add(0, 8'hA5); exp_add(1, 8'h05); exp_add(0, 8'h00);
    repeat (2) @(negedge clk);
    compare_log("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
